branch_predictor: RTL and testbench

Front-end branch predictor pairing with the execute-stage branch resolver. Predicts direction and target for each fetched PC using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Receives resolved outcomes (taken flag, target address) back from execute, trains its tables, and raises a registered mispredict/redirect to fetch.

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters and a registered mispredict/redirect.
// Optional resolved-branch statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter  int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        flush,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic             pred_valid_q, pred_taken_q;
  logic [31:0]      pred_target_q;
  logic             mispredict_q;
  logic [31:0]      redirect_pc_q;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, f_taken;
  logic [31:0]      f_target;
  logic             u_hit, u_write, mis_d;
  logic [1:0]       ctr_cur, ctr_d;
  logic [31:0]      redirect_d;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  always_comb begin
    f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken  = f_hit && ctr_q[f_idx][1];
    f_target = f_taken ? target_q[f_idx] : fetch_pc + 32'd4;
  end

  // A miss only allocates on a taken outcome; not-taken misses leave the table alone.
  always_comb begin
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_cur = ctr_q[u_idx];
    ctr_d   = ctr_cur;
    if (u_hit) begin
      if (upd_taken) begin
        if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
      end else begin
        if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
      end
    end else begin
      ctr_d = 2'b10;
    end
    u_write    = upd_valid && (u_hit || upd_taken);
    mis_d      = upd_valid && ((upd_taken != upd_pred_taken) ||
                               (upd_taken && (upd_target != upd_pred_target)));
    redirect_d = upd_taken ? upd_target : upd_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (u_write) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      ctr_q[u_idx]   <= ctr_d;
      if (upd_taken) target_q[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      pred_valid_q  <= fetch_valid && !flush;
      pred_taken_q  <= fetch_valid && !flush && f_taken;
      pred_target_q <= f_target;
      mispredict_q  <= mis_d;
      if (upd_valid) redirect_pc_q <= redirect_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (upd_valid) stat_br_q  <= stat_br_q + 32'd1;
      if (mis_d)     stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (ENTRIES=16); stat checks compile in with BP_STATS_EN.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, flush, upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] fetch_pc, upd_pc, upd_target, upd_pred_target;
  logic        pred_valid, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct { logic v; logic t; logic [31:0] tgt; } pexp_t;
  typedef struct { logic m; logic [31:0] r; } mexp_t;
  pexp_t pq[$];
  mexp_t mq[$];

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drain();
    pexp_t p;
    mexp_t m;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      chk("pred_valid", {31'b0, pred_valid}, {31'b0, p.v});
      if (p.v) begin
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, p.t});
        chk("pred_target", pred_target, p.tgt);
      end
    end
    while (mq.size() > 0) begin
      m = mq.pop_front();
      chk("mispredict", {31'b0, mispredict}, {31'b0, m.m});
      if (m.m) chk("redirect_pc", redirect_pc, m.r);
    end
  endtask

  task automatic step(input logic fv, input logic [31:0] fpc, input logic fl,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    fetch_valid = fv; fetch_pc = fpc; flush = fl;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt;
    @(posedge clk); #1;
    fetch_valid = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    drain();
  endtask

  task automatic fetch(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    pq.push_back('{1'b1, et, etgt});
    mq.push_back('{1'b0, 32'h0});
    step(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt,
                     input logic em, input logic [31:0] er);
    pq.push_back('{1'b0, 1'b0, 32'h0});
    mq.push_back('{em, er});
    step(1'b0, 32'h0, 1'b0, 1'b1, pc, t, tgt, pt, ptgt);
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    fetch_pc = '0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pred_valid", {31'b0, pred_valid}, 32'h0);
    chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("rst_pred_target", pred_target, 32'h0);
    chk("rst_mispredict", {31'b0, mispredict}, 32'h0);
    chk("rst_redirect", redirect_pc, 32'h0);
`ifdef BP_STATS_EN
    chk("rst_stat_br", stat_branches, 32'h0);
    chk("rst_stat_mis", stat_mispredicts, 32'h0);
`endif
    rst = 1'b0;

    fetch(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);   // allocate, ctr=10
    fetch(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);     // 11
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);     // saturated
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0,  1'b1, 32'h80, 1'b1, 32'h104);   // 10
`ifdef BP_STATS_EN
    chk("stat_branches", stat_branches, 32'd5);
    chk("stat_mispredicts", stat_mispredicts, 32'd2);
`endif
    fetch(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);    // 01
    fetch(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'hDEAD, 1'b0, 32'h0);    // 00, direction-only compare
    fetch(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);    // target mismatch, ctr 01
    fetch(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h90, 1'b0, 32'h104, 1'b1, 32'h90);   // ctr 10
    fetch(32'h100, 1'b1, 32'h90);

    upd(32'h140, 1'b1, 32'hA0, 1'b0, 32'h144, 1'b1, 32'hA0);   // alias replaces index 0
    fetch(32'h100, 1'b0, 32'h104);
    fetch(32'h140, 1'b1, 32'hA0);

    // simultaneous lookup and allocating update: lookup sees old entry
    pq.push_back('{1'b1, 1'b0, 32'h204});
    mq.push_back('{1'b1, 32'h300});
    step(1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    fetch(32'h200, 1'b1, 32'h300);

    pq.push_back('{1'b0, 1'b0, 32'h0});
    mq.push_back('{1'b0, 32'h0});
    step(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);  // flush
    pq.push_back('{1'b0, 1'b0, 32'h0});
    mq.push_back('{1'b0, 32'h0});
    step(1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);  // idle

    rst = 1'b1;
    pq.push_back('{1'b0, 1'b0, 32'h0});
    mq.push_back('{1'b0, 32'h0});
    step(1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
    rst = 1'b0;
`ifdef BP_STATS_EN
    chk("rst2_stat_br", stat_branches, 32'h0);
    chk("rst2_stat_mis", stat_mispredicts, 32'h0);
`endif
    fetch(32'h200, 1'b0, 32'h204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
